// File: rtl/rr_arb8_ctrl.sv
// rr_arb8_ctrl: round-robin arbiter/sequencer sharing one val/rdy channel
// among 8 requesters. A grant is burst-atomic: it is held until the
// granted requester's last beat is accepted, or until p_max_burst beats
// have been accepted, whichever comes first. Every release is followed by
// one IDLE cycle in which the next winner is chosen.
module rr_arb8_ctrl #(
  parameter int p_max_burst = 16  // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst,          // synchronous, active-low
  input  logic [7:0] req_val,
  input  logic [7:0] req_last,
  output logic [7:0] req_rdy,
  output logic       out_val,
  output logic       out_last,
  input  logic       out_rdy,
  output logic [2:0] sel,
  output logic       busy,
  output logic       burst_trunc
);

  // Beat count value on which the fairness cap forces release.
  localparam logic [7:0] CAP_CNT = 8'(p_max_burst - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] prio_q, prio_d;        // index with highest priority
  logic [2:0] grant_q, grant_d;      // currently granted requester
  logic [7:0] beat_cnt_q, beat_cnt_d; // beats accepted in this grant

  logic       cap_s;
  logic       out_val_s;
  logic       out_last_s;
  logic       xfer_s;
  logic [7:0] req_rdy_s;
  logic       busy_s;
  logic       trunc_s;
  logic [2:0] pick_s;

  // Circular first-set scan starting at prio; returns the winning index.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] prio);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = prio + 3'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign pick_s = rr_pick(req_val, prio_q);

  // Channel outputs, derived from the registered grant; forced quiet while
  // reset is asserted so an abandoned burst never accepts a partial beat.
  always_comb begin
    cap_s      = 1'b0;
    out_val_s  = 1'b0;
    out_last_s = 1'b0;
    xfer_s     = 1'b0;
    req_rdy_s  = 8'h00;
    busy_s     = 1'b0;
    trunc_s    = 1'b0;
    if (!rst) begin
      busy_s = 1'b0;
    end else if (state_q == ST_BUSY) begin
      busy_s             = 1'b1;
      cap_s              = (beat_cnt_q == CAP_CNT);
      out_val_s          = req_val[grant_q];
      out_last_s         = out_val_s & (req_last[grant_q] | cap_s);
      xfer_s             = out_val_s & out_rdy;
      req_rdy_s[grant_q] = out_rdy;
      trunc_s            = xfer_s & cap_s & ~req_last[grant_q];
    end else begin
      busy_s = 1'b0;
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and release in BUSY.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_val != 8'h00) begin
          grant_d    = pick_s;
          beat_cnt_d = 8'd0;
          state_d    = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (xfer_s && out_last_s) begin
          // Released grantee drops to lowest priority next round.
          prio_d     = grant_q + 3'd1;
          beat_cnt_d = 8'd0;
          state_d    = ST_IDLE;
        end else if (xfer_s) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        prio_d     = 3'd0;
        grant_d    = 3'd0;
        beat_cnt_d = 8'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      prio_q     <= 3'd0;
      grant_q    <= 3'd0;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Select is meaningful only while a grant is held; zero otherwise.
  assign sel         = busy_s ? grant_q : 3'd0;
  assign busy        = busy_s;
  assign out_val     = out_val_s;
  assign out_last    = out_last_s;
  assign req_rdy     = req_rdy_s;
  assign burst_trunc = trunc_s;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Directed, table-driven bench for rr_arb8_ctrl with p_max_burst = 4.
// Inputs are applied just after a rising edge, outputs are compared at
// the falling edge of the same cycle.
module tb_rr_arb8_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_val;
  logic [7:0] req_last;
  logic [7:0] req_rdy;
  logic       out_val;
  logic       out_last;
  logic       out_rdy;
  logic [2:0] sel;
  logic       busy;
  logic       burst_trunc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arb8_ctrl #(.p_max_burst(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_last   (req_last),
    .req_rdy    (req_rdy),
    .out_val    (out_val),
    .out_last   (out_last),
    .out_rdy    (out_rdy),
    .sel        (sel),
    .busy       (busy),
    .burst_trunc(burst_trunc)
  );

  typedef struct packed {
    logic       rst;
    logic [7:0] val;
    logic [7:0] last;
    logic       rdy;
    logic       e_val;
    logic       e_last;
    logic [7:0] e_rdy;
    logic [2:0] e_sel;
    logic       e_busy;
    logic       e_trunc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [7:0] v,
                              input logic [7:0] l, input logic rd,
                              input logic ev, input logic el,
                              input logic [7:0] erd, input logic [2:0] es,
                              input logic eb, input logic et);
    vec_t x;
    x.rst = r;  x.val = v;  x.last = l;  x.rdy = rd;
    x.e_val = ev; x.e_last = el; x.e_rdy = erd; x.e_sel = es;
    x.e_busy = eb; x.e_trunc = et;
    return x;
  endfunction

  task automatic cmp(input string tag, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  // Apply one cycle of inputs, compare outputs mid-cycle, advance one edge.
  task automatic step(input vec_t v, input string tag);
    rst      = v.rst;
    req_val  = v.val;
    req_last = v.last;
    out_rdy  = v.rdy;
    @(negedge clk);
    cmp({tag, ".out_val"},     int'(out_val),     int'(v.e_val));
    cmp({tag, ".out_last"},    int'(out_last),    int'(v.e_last));
    cmp({tag, ".req_rdy"},     int'(req_rdy),     int'(v.e_rdy));
    cmp({tag, ".sel"},         int'(sel),         int'(v.e_sel));
    cmp({tag, ".busy"},        int'(busy),        int'(v.e_busy));
    cmp({tag, ".burst_trunc"}, int'(burst_trunc), int'(v.e_trunc));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; req_val = 8'h00; req_last = 8'h00; out_rdy = 1'b0;

    // Reset held two cycles with all requests high; then first grant to 0.
    vecs.push_back(mk(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0));
    // Single requester 5: out_val 0,1,0,1,0,1.
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(1'b1, 8'h20, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h20, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0));
    end
    // Reset to prio 0, then full round-robin 0..7 and wrap back to 0.
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    for (int k = 0; k < 9; k++) begin
      vecs.push_back(mk(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h01 << (k % 8),
                        3'(k % 8), 1'b1, 1'b0));
    end
    // Requester 2 bursts 3 beats under backpressure while 6 waits (prio=1).
    vecs.push_back(mk(1'b1, 8'h44, 8'h40, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h44, 8'h40, 1'b1, 1'b1, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h44, 8'h40, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h44, 8'h40, 1'b1, 1'b1, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h44, 8'h44, 1'b0, 1'b1, 1'b1, 8'h00, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h44, 8'h44, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h40, 8'h40, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h40, 8'h40, 1'b1, 1'b1, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Cap at 4 beats: requester 3 alone, never asserting req_last (prio=7).
    step(mk(1'b1, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), "cap.arb");
    for (int b = 1; b <= 3; b++) begin
      step(mk(1'b1, 8'h08, 8'h00, 1'b1, 1'b1, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0),
           $sformatf("cap.beat%0d", b));
    end
    step(mk(1'b1, 8'h08, 8'h00, 1'b1, 1'b1, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1), "cap.beat4");
    step(mk(1'b1, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), "cap.bubble");
    step(mk(1'b1, 8'h08, 8'h00, 1'b1, 1'b1, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0), "cap.regrant");
    // Withdrawal: grant and sel held, out_val drops.
    step(mk(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0), "withdraw");

    // Mid-burst reset: clean reset, grant 4 for two beats, then reset.
    step(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), "mr.pre");
    step(mk(1'b1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), "mr.arb");
    step(mk(1'b1, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0), "mr.beat1");
    step(mk(1'b1, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0), "mr.beat2");
    step(mk(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), "mr.rst");
    step(mk(1'b1, 8'h11, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), "mr.idle");
    step(mk(1'b1, 8'h11, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0), "mr.grant0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
